prf_scoreboard: RTL and testbench
=================================

Name: prf_scoreboard

Overview:
- Parametrised multi-ported physical register file with a per-entry ready scoreboard.
- Successor to the 4x8-bit, 2-read/1-write architectural register file; sized for the out-of-order core's rename/issue stage.
- Provides N read ports with same-cycle write bypass and M writeback ports.
- Rename allocation clears an entry's ready bit; writeback sets it; flush restores all entries to ready.

Parameters:
- DATA_W, 8, register data width in bits.
- NUM_REGS, 16, number of physical registers; must be a power of two, >= 4.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write (writeback) ports.
- ZERO_REG, 1, when 1, entry 0 reads as 0, is always ready, and ignores writes and allocs.
- AW (derived, not overridable), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_ready  out  NUM_RD  per-port operand-ready flag, combinational.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- alloc_en  in  1  rename allocation strobe.
- alloc_addr  in  AW  entry to mark busy.
- flush  in  1  pipeline flush; all entries become ready.
- busy_count  out  AW+1  number of entries currently not ready (registered).
- wr_conflict  out  1  sticky error flag: two write ports hit the same address in one cycle.

Behaviour:
- Reset (async, rst=1):
  - All data entries 0; all ready bits 1.
  - busy_count=0; wr_conflict=0.
  - Combinational outputs follow the reset state immediately.
- Read (combinational, zero latency):
  - Write hit = wr_en[j]=1 and wr_addr[j]==rd_addr[i] for any j.
  - On a write hit, rd_data[i] = wr_data of the highest-index hitting port, and rd_ready[i]=1.
  - With no hit, rd_data[i] = stored entry and rd_ready[i] = stored ready bit.
  - ZERO_REG=1 and rd_addr=0: rd_data=0 and rd_ready=1 always; bypass does not apply.
- Write (posedge):
  - For each enabled port, entry <= wr_data and ready <= 1.
  - Same address on several ports: the highest-index port's data is stored.
  - Writes to entry 0 are dropped when ZERO_REG=1.
- Allocation (posedge):
  - alloc_en=1 sets ready[alloc_addr] <= 0; data is untouched.
  - alloc_addr=0 is ignored when ZERO_REG=1.
- Simultaneous events on the same entry in one cycle:
  - alloc + write: data is written; ready ends 0 (alloc wins — the new producer owns the entry).
  - flush + alloc: flush wins; ready ends 1. Writes in the flush cycle still update data.
- Flush (posedge): every ready bit <= 1; busy_count <= 0.
- busy_count:
  - Registered; always equals the number of ready==0 entries after the same edge.
  - Never exceeds NUM_REGS-ZERO_REG.
  - May be implemented as an up/down counter (+1 on alloc of a ready entry, -1 per distinct ready==0 entry written, net of overlaps) or as a registered popcount. It must match the popcount in every cycle.
  - Alloc of an already-busy entry: no change.
- wr_conflict:
  - Set at the posedge when two or more enabled write ports share an address (entry 0 excluded when ZERO_REG=1).
  - Held until rst.
- Reset mid-operation: asynchronous reset overrides all pending writes, allocs and flush in that cycle.
- No internal FSM beyond the scoreboard. Single-cycle operation; no back-pressure.

Test Plan:
- Reset, then read all ports at addr 0..3 -> rd_data=0, rd_ready=1, busy_count=0, wr_conflict=0.
- alloc_en addr 5 -> next cycle rd_ready=0 at addr 5, busy_count=1. Then wr_en[0] addr 5 data 0xA7 -> same cycle rd_data=0xA7 and rd_ready=1 (bypass); next cycle the stored value is 0xA7, ready=1, busy_count=0.
- Same-cycle alloc and write to addr 3 (data 0x3C) -> next cycle data 0x3C, ready=0, busy_count=1. A flush in a later cycle -> busy_count=0, all ready.
- wr_en=2'b11, both ports to addr 7, data 0x11 on port 0 and 0x22 on port 1 -> bypass shows 0x22, stored 0x22, wr_conflict=1 and stays set. Reset clears it.
- ZERO_REG=1: write 0xFF and alloc to addr 0 -> rd_data=0, rd_ready=1, busy_count unchanged, wr_conflict unaffected.
- Alloc 15 distinct entries, then assert rst mid-stream -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prf_scoreboard.sv
// Multi-ported physical register file with per-entry ready scoreboard.
// Reads bypass same-cycle writebacks; busy_count tracks entries that are not ready.
module prf_scoreboard #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     flush,
  output logic [AW:0]              busy_count,
  output logic                     wr_conflict
);

  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [DATA_W-1:0]   data_d [NUM_REGS];
  logic [NUM_REGS-1:0] ready_q, ready_d;
  logic [CW-1:0]       busy_count_q, busy_count_d;
  logic                wr_conflict_q, wr_conflict_d;

  // Combinational read with highest-index writeback bypass.
  always_comb begin
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] val;
    logic              rdy;
    rd_data  = '0;
    rd_ready = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      val = data_q[ra];
      rdy = ready_q[ra];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
          val = wr_data[j*DATA_W +: DATA_W];
          rdy = 1'b1;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        val = '0;
        rdy = 1'b1;
      end
      rd_data[i*DATA_W +: DATA_W] = val;
      rd_ready[i]                 = rdy;
    end
  end

  // Next state: writes, then alloc (beats write), then flush (beats alloc).
  always_comb begin
    logic [AW-1:0] wa;
    logic [CW-1:0] cnt;
    data_d        = data_q;
    ready_d       = ready_q;
    wr_conflict_d = wr_conflict_q;
    cnt           = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wa = wr_addr[j*AW +: AW];
      if (wr_en[j] && !((ZERO_REG != 0) && (wa == '0))) begin
        data_d[wa]  = wr_data[j*DATA_W +: DATA_W];
        ready_d[wa] = 1'b1;
      end
      for (int unsigned k = j + 1; k < NUM_WR; k++) begin
        if (wr_en[j] && wr_en[k] && (wr_addr[k*AW +: AW] == wa) &&
            !((ZERO_REG != 0) && (wa == '0))) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
    if (alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0))) begin
      ready_d[alloc_addr] = 1'b0;
    end
    if (flush) begin
      ready_d = '1;
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (!ready_d[r]) cnt = cnt + CW'(1);
    end
    busy_count_d = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) data_q[r] <= '0;
      ready_q       <= '1;
      busy_count_q  <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      ready_q       <= ready_d;
      busy_count_q  <= busy_count_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign busy_count  = busy_count_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_prf_scoreboard.sv
// Directed bench for prf_scoreboard with default parameters (16x8, 4 read, 2 write).
module tb_prf_scoreboard;

  logic        clk;
  logic        rst;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_ready;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        alloc_en;
  logic [3:0]  alloc_addr;
  logic        flush;
  logic [4:0]  busy_count;
  logic        wr_conflict;

  int errors = 0;
  int checks = 0;

  prf_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_count (busy_count),
    .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    rd_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data[p*8 +: 8] !== 8'h00) begin
        errors++; $display("FAIL reset_data port%0d: got %h expected 00", p, rd_data[p*8 +: 8]);
      end
      checks++;
      if (rd_ready[p] !== 1'b1) begin
        errors++; $display("FAIL reset_ready port%0d: got %b expected 1", p, rd_ready[p]);
      end
    end
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL reset_busy: got %0d expected 0", busy_count);
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_conflict: got %b expected 0", wr_conflict);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alloc_bypass();
    alloc_en = 1'b1; alloc_addr = 4'd5;
    tick();
    idle();
    rd_addr[3:0] = 4'd5;
    #1;
    checks++;
    if (rd_ready[0] !== 1'b0) begin
      errors++; $display("FAIL alloc_ready: got %b expected 0", rd_ready[0]);
    end
    checks++;
    if (busy_count !== 5'd1) begin
      errors++; $display("FAIL alloc_busy: got %0d expected 1", busy_count);
    end
    wr_en = 2'b01; wr_addr[3:0] = 4'd5; wr_data[7:0] = 8'hA7;
    #1;
    checks++;
    if (rd_data[7:0] !== 8'hA7) begin
      errors++; $display("FAIL bypass_data: got %h expected a7", rd_data[7:0]);
    end
    checks++;
    if (rd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bypass_ready: got %b expected 1", rd_ready[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[7:0] !== 8'hA7) begin
      errors++; $display("FAIL stored_data: got %h expected a7", rd_data[7:0]);
    end
    checks++;
    if (rd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL stored_ready: got %b expected 1", rd_ready[0]);
    end
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL writeback_busy: got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_alloc_write();
    alloc_en = 1'b1; alloc_addr = 4'd3;
    wr_en = 2'b01; wr_addr[3:0] = 4'd3; wr_data[7:0] = 8'h3C;
    tick();
    idle();
    rd_addr[7:4] = 4'd3;
    #1;
    checks++;
    if (rd_data[15:8] !== 8'h3C) begin
      errors++; $display("FAIL allocwr_data: got %h expected 3c", rd_data[15:8]);
    end
    checks++;
    if (rd_ready[1] !== 1'b0) begin
      errors++; $display("FAIL allocwr_ready: got %b expected 0", rd_ready[1]);
    end
    checks++;
    if (busy_count !== 5'd1) begin
      errors++; $display("FAIL allocwr_busy: got %0d expected 1", busy_count);
    end
    tick();
    flush = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL flush_busy: got %0d expected 0", busy_count);
    end
    checks++;
    if (rd_ready[1] !== 1'b1) begin
      errors++; $display("FAIL flush_ready: got %b expected 1", rd_ready[1]);
    end
  endtask

  task automatic test_flush_alloc();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 4'd6;
    wr_en = 2'b10; wr_addr[7:4] = 4'd6; wr_data[15:8] = 8'h66;
    tick();
    idle();
    rd_addr[11:8] = 4'd6;
    #1;
    checks++;
    if (rd_ready[2] !== 1'b1) begin
      errors++; $display("FAIL flushalloc_ready: got %b expected 1", rd_ready[2]);
    end
    checks++;
    if (rd_data[23:16] !== 8'h66) begin
      errors++; $display("FAIL flushalloc_data: got %h expected 66", rd_data[23:16]);
    end
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL flushalloc_busy: got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_conflict();
    wr_en = 2'b11; wr_addr = {4'd7, 4'd7}; wr_data = {8'h22, 8'h11};
    rd_addr[11:8] = 4'd7;
    #1;
    checks++;
    if (rd_data[23:16] !== 8'h22) begin
      errors++; $display("FAIL conflict_bypass: got %h expected 22", rd_data[23:16]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[23:16] !== 8'h22) begin
      errors++; $display("FAIL conflict_stored: got %h expected 22", rd_data[23:16]);
    end
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_set: got %b expected 1", wr_conflict);
    end
    tick();
    tick();
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky: got %b expected 1", wr_conflict);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_reset: got %b expected 0", wr_conflict);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b11; wr_addr = {4'd0, 4'd0}; wr_data = {8'hFF, 8'hFF};
    alloc_en = 1'b1; alloc_addr = 4'd0;
    rd_addr[3:0] = 4'd0;
    #1;
    checks++;
    if (rd_data[7:0] !== 8'h00) begin
      errors++; $display("FAIL zero_bypass_data: got %h expected 00", rd_data[7:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[7:0] !== 8'h00) begin
      errors++; $display("FAIL zero_data: got %h expected 00", rd_data[7:0]);
    end
    checks++;
    if (rd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got %b expected 1", rd_ready[0]);
    end
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL zero_busy: got %0d expected 0", busy_count);
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL zero_conflict: got %b expected 0", wr_conflict);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 2'b01; wr_addr[3:0] = 4'd2; wr_data[7:0] = 8'h5A;
    tick();
    idle();
    for (int k = 1; k <= 15; k++) begin
      alloc_en = 1'b1; alloc_addr = 4'(k);
      tick();
      checks++;
      if (busy_count !== 5'(k)) begin
        errors++; $display("FAIL b2b_busy alloc%0d: got %0d expected %0d", k, busy_count, k);
      end
    end
    alloc_addr = 4'd1;
    tick();
    idle();
    checks++;
    if (busy_count !== 5'd15) begin
      errors++; $display("FAIL realloc_busy: got %0d expected 15", busy_count);
    end
    wr_en = 2'b11; wr_addr = {4'd9, 4'd4}; wr_data = {8'h99, 8'h44};
    tick();
    idle();
    checks++;
    if (busy_count !== 5'd13) begin
      errors++; $display("FAIL dual_wb_busy: got %0d expected 13", busy_count);
    end
    rd_addr = {4'd9, 4'd4, 4'd2, 4'd1};
    #1;
    checks++;
    if (rd_ready !== 4'b1100) begin
      errors++; $display("FAIL pre_reset_ready: got %b expected 1100", rd_ready);
    end
    checks++;
    if (rd_data[15:8] !== 8'h5A) begin
      errors++; $display("FAIL pre_reset_data: got %h expected 5a", rd_data[15:8]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_count !== 5'd0) begin
      errors++; $display("FAIL async_reset_busy: got %0d expected 0", busy_count);
    end
    checks++;
    if (rd_ready !== 4'b1111) begin
      errors++; $display("FAIL async_reset_ready: got %b expected 1111", rd_ready);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL async_reset_data: got %h expected 00000000", rd_data);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    idle();
    test_reset();
    test_alloc_bypass();
    test_alloc_write();
    test_flush_alloc();
    test_conflict();
    test_zero_reg();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
